// File: rtl/a2d_intf_if.sv
// a2d_intf_if: bundles the conversion request, the ADC SPI pins and the result bus of a2d_intf.
// Signals: nxt (request), MISO/SS_n/SCLK/MOSI (ADC SPI), lft_ld/rght_ld/batt (12-bit results),
//          busy, cnv_done. master = converter side (a2d_intf), slave = core / ADC side.
interface a2d_intf_if;
  logic        nxt;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        busy;
  logic        cnv_done;

  modport master (
    input  nxt, MISO,
    output SS_n, SCLK, MOSI, lft_ld, rght_ld, batt, busy, cnv_done
  );

  modport slave (
    output nxt, MISO,
    input  SS_n, SCLK, MOSI, lft_ld, rght_ld, batt, busy, cnv_done
  );
endinterface

// File: rtl/a2d_intf.sv
// a2d_intf: round-robin SPI ADC front end (left load, right load, battery) with held 12-bit results.
// Ports: clk, rst (sync, active high), bus (a2d_intf_if.master: nxt, MISO in; SPI pins, results, busy, cnv_done out).
// Latency: two 16-bit frames + 2-cycle gap + 1 update cycle per nxt; nxt is dropped (not queued) while busy.
module a2d_intf #(
  parameter int unsigned SCLK_DIV = 32,
  parameter logic [2:0]  CH_LFT   = 3'd0,
  parameter logic [2:0]  CH_RGHT  = 3'd4,
  parameter logic [2:0]  CH_BATT  = 3'd5
) (
  input logic         clk,
  input logic         rst,
  a2d_intf_if.master  bus
);

  localparam int unsigned HALF = SCLK_DIV / 2;
  localparam int unsigned DW   = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] HALF_V    = DW'(HALF);
  localparam logic [DW-1:0] HALF_LAST = DW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;
  typedef enum logic [1:0] {IDX_LFT, IDX_RGHT, IDX_BATT} idx_t;

  state_t         state, state_nxt;
  idx_t           idx;
  logic           frame_start;
  logic           frame_end;
  logic           act;        // chip select asserted (inside a frame)
  logic [DW-1:0]  div_cnt;    // position within the current SCLK period
  logic [4:0]     rise_cnt;   // SCLK rising edges so far in this frame
  logic           gap_cnt;
  logic [15:0]    tx_sh;
  logic [11:0]    rx_sh;      // only the low 12 bits of the received word survive 16 shifts
  logic [11:0]    lft_q, rght_q, batt_q;
  logic           done_q;
  logic [2:0]     ch;
  logic [15:0]    cmd;

  always_comb begin
    ch = CH_LFT;
    case (idx)
      IDX_RGHT: ch = CH_RGHT;
      IDX_BATT: ch = CH_BATT;
      default:  ch = CH_LFT;
    endcase
  end

  assign cmd = {2'b00, ch, 11'h000};

  // Last frame cycle: HALF cycles after the 16th SCLK rise.
  assign frame_end = act && (rise_cnt == 5'd16) && (div_cnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (bus.nxt) begin
          state_nxt   = XFER1;
          frame_start = 1'b1;
        end
      end
      XFER1: begin
        if (frame_end) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt) begin
          state_nxt   = XFER2;
          frame_start = 1'b1;
        end
      end
      XFER2: begin
        // One extra cycle after the frame closes carries the result update.
        if (!act) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act      <= 1'b0;
      div_cnt  <= '0;
      rise_cnt <= '0;
      gap_cnt  <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      lft_q    <= '0;
      rght_q   <= '0;
      batt_q   <= '0;
      done_q   <= 1'b0;
      idx      <= IDX_LFT;
    end else begin
      done_q  <= 1'b0;
      gap_cnt <= (state == GAP) ? ~gap_cnt : 1'b0;
      if (frame_start) begin
        act      <= 1'b1;
        div_cnt  <= '0;
        rise_cnt <= '0;
        tx_sh    <= cmd;
      end else if (act) begin
        if (frame_end) act <= 1'b0;
        // The edge leaving the last cycle of a period is the SCLK rise: sample MISO there.
        if (div_cnt == DIV_LAST) begin
          div_cnt  <= '0;
          rise_cnt <= rise_cnt + 5'd1;
          rx_sh    <= {rx_sh[10:0], bus.MISO};
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        // Advance MOSI on every SCLK fall except the first (bit 15 is already out).
        if ((div_cnt == HALF_LAST) && (rise_cnt != 5'd0)) tx_sh <= {tx_sh[14:0], 1'b0};
        if (frame_end && (state == XFER2)) begin
          done_q <= 1'b1;
          case (idx)
            IDX_RGHT: begin rght_q <= rx_sh; idx <= IDX_BATT; end
            IDX_BATT: begin batt_q <= rx_sh; idx <= IDX_LFT;  end
            default:  begin lft_q  <= rx_sh; idx <= IDX_RGHT; end
          endcase
        end
      end
    end
  end

  assign bus.SS_n     = ~act;
  assign bus.SCLK     = ~(act && (div_cnt >= HALF_V));
  assign bus.MOSI     = act & tx_sh[15];
  assign bus.lft_ld   = lft_q;
  assign bus.rght_ld  = rght_q;
  assign bus.batt     = batt_q;
  assign bus.busy     = (state != IDLE);
  assign bus.cnv_done = done_q;

endmodule
